// File: rtl/id_fwd_stage_pkg.sv
// Shared definitions for the ID stage: payload layout, forward-entry field map,
// LA32 opcode constants and the source-operand usage table.
package id_fwd_stage_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned FS_DS_W    = INST_W + PC_W;
  localparam int unsigned REG_FIELD_W = 5;

  // Forward entry = {valid, we, ready, addr, data}; offsets below are inside the 3-bit control field
  localparam int unsigned FWD_CTRL_W    = 3;
  localparam int unsigned FWD_VALID_OFS = 2;
  localparam int unsigned FWD_WE_OFS    = 1;
  localparam int unsigned FWD_READY_OFS = 0;

  function automatic int unsigned fwd_w(input int unsigned aw, input int unsigned dw);
    return FWD_CTRL_W + aw + dw;
  endfunction

  // Opcode prefixes, matched against inst[31:20]
  localparam logic [5:0]  OP6_B       = 6'b010100;
  localparam logic [5:0]  OP6_BL      = 6'b010101;
  localparam logic [5:0]  OP6_BEQ     = 6'b010110;
  localparam logic [5:0]  OP6_BNE     = 6'b010111;
  localparam logic [6:0]  OP7_LU12I_W = 7'b0001010;
  localparam logic [9:0]  OP10_ST_W   = 10'b0010100110;
  localparam logic [11:0] OP12_3R     = 12'h001;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fs_ds_bus_t;

  typedef struct packed {
    logic src1_en;
    logic src2_en;
    logic src2_is_rd;
  } src_use_t;

  // Which register operands an instruction reads, and where src2 lives
  function automatic src_use_t src_use_of(input logic [11:0] op);
    src_use_t u;
    logic is_b, is_bl, is_beq, is_bne, is_lu12i, is_st, is_3r;
    is_b     = (op[11:6] == OP6_B);
    is_bl    = (op[11:6] == OP6_BL);
    is_beq   = (op[11:6] == OP6_BEQ);
    is_bne   = (op[11:6] == OP6_BNE);
    is_lu12i = (op[11:5] == OP7_LU12I_W);
    is_st    = (op[11:2] == OP10_ST_W);
    is_3r    = (op == OP12_3R);
    u.src1_en    = ~(is_b | is_bl | is_lu12i);
    u.src2_en    = is_beq | is_bne | is_st | is_3r;
    u.src2_is_rd = is_beq | is_bne | is_st;
    return u;
  endfunction

endpackage

// File: rtl/id_fwd_stage_src_decode.sv
// Source-operand decode: instruction -> register read enables and addresses.
module id_src_decode
  import id_fwd_stage_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [INST_W-1:0] inst,
  output logic              src1_en,
  output logic              src2_en,
  output logic [AW-1:0]     raddr1,
  output logic [AW-1:0]     raddr2
);

  src_use_t use_c;
  logic     unused_imm_bits;

  always_comb begin
    use_c = src_use_of(inst[31:20]);
  end

  assign src1_en = use_c.src1_en;
  assign src2_en = use_c.src2_en;
  assign raddr1  = AW'(inst[9:5]);
  assign raddr2  = use_c.src2_is_rd ? AW'(inst[4:0]) : AW'(inst[14:10]);

  // Immediate/opcode-tail bits carry no register information
  assign unused_imm_bits = ^inst[19:15];

endmodule

// File: rtl/id_fwd_stage.sv
// Decode pipeline slot with RAW bypassing from NUM_FWD producer stages.
// Define ID_FWD_EN for the bypass mux; without it the stage interlocks on every match.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic                                        fs_to_ds_valid,
  input  logic [FS_DS_W-1:0]                          fs_to_ds_bus,
  output logic                                        ds_allowin,
  input  logic                                        es_allowin,
  input  logic                                        ds_flush,
  output logic                                        ds_to_es_valid,
  output logic [FS_DS_W+2*DATA_W-1:0]                 ds_to_es_bus,
  output logic [AW-1:0]                               rf_raddr1,
  output logic [AW-1:0]                               rf_raddr2,
  input  logic [DATA_W-1:0]                           rf_rdata1,
  input  logic [DATA_W-1:0]                           rf_rdata2,
  input  logic [NUM_FWD*(FWD_CTRL_W+AW+DATA_W)-1:0]   fwd_bus,
  output logic [CNT_W-1:0]                            stall_cnt
);

  localparam int unsigned FWD_W   = fwd_w(AW, DATA_W);
  localparam int unsigned CTRL_LSB = DATA_W + AW;

  logic        ds_valid;
  fs_ds_bus_t  ds_payload;
  logic        ds_ready_go;
  logic        src1_en, src2_en;
  logic        src1_chk, src2_chk;
  logic        src1_stall, src2_stall;
  logic [DATA_W-1:0] src1_sel, src2_sel;
  logic [DATA_W-1:0] src1_val, src2_val;
  logic [NUM_FWD-1:0] hit1_vec, hit2_vec;

  id_src_decode #(.AW(AW)) u_src_decode (
    .inst    (ds_payload.inst),
    .src1_en (src1_en),
    .src2_en (src2_en),
    .raddr1  (rf_raddr1),
    .raddr2  (rf_raddr2)
  );

  // r0 is hard-wired zero, so it can never be the target of a producer
  assign src1_chk = src1_en & (rf_raddr1 != '0);
  assign src2_chk = src2_en & (rf_raddr2 != '0);

`ifdef ID_FWD_EN
  logic [NUM_FWD-1:0]        rdy_vec;
  logic [NUM_FWD*DATA_W-1:0] data_vec;
  logic                      hit1, hit2, rdy1, rdy2;
  logic [DATA_W-1:0]         byp1, byp2;
`endif

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    logic [FWD_W-1:0] ent;
    logic [AW-1:0]    ent_addr;
    logic             ent_live;
    assign ent      = fwd_bus[i*FWD_W +: FWD_W];
    assign ent_addr = ent[DATA_W +: AW];
    assign ent_live = ent[CTRL_LSB+FWD_VALID_OFS] & ent[CTRL_LSB+FWD_WE_OFS];
    assign hit1_vec[i] = ent_live & src1_chk & (ent_addr == rf_raddr1);
    assign hit2_vec[i] = ent_live & src2_chk & (ent_addr == rf_raddr2);
`ifdef ID_FWD_EN
    assign rdy_vec[i]                  = ent[CTRL_LSB+FWD_READY_OFS];
    assign data_vec[i*DATA_W +: DATA_W] = ent[DATA_W-1:0];
`else
    logic unused_ent;
    assign unused_ent = ^ent;
`endif
  end

`ifdef ID_FWD_EN
  // Priority select: scan oldest to youngest so the lowest index wins,
  // including when the youngest match is not ready yet
  always_comb begin
    hit1 = 1'b0;
    rdy1 = 1'b1;
    byp1 = rf_rdata1;
    hit2 = 1'b0;
    rdy2 = 1'b1;
    byp2 = rf_rdata2;
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (hit1_vec[k]) begin
        hit1 = 1'b1;
        rdy1 = rdy_vec[k];
        byp1 = data_vec[k*DATA_W +: DATA_W];
      end
      if (hit2_vec[k]) begin
        hit2 = 1'b1;
        rdy2 = rdy_vec[k];
        byp2 = data_vec[k*DATA_W +: DATA_W];
      end
    end
  end

  assign src1_stall = hit1 & ~rdy1;
  assign src2_stall = hit2 & ~rdy2;
  assign src1_sel   = byp1;
  assign src2_sel   = byp2;
`else
  assign src1_stall = |hit1_vec;
  assign src2_stall = |hit2_vec;
  assign src1_sel   = rf_rdata1;
  assign src2_sel   = rf_rdata2;
`endif

  assign src1_val = (rf_raddr1 == '0) ? '0 : src1_sel;
  assign src2_val = (rf_raddr2 == '0) ? '0 : src2_sel;

  assign ds_ready_go    = ~(src1_stall | src2_stall);
  assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid & ds_ready_go;
  assign ds_to_es_bus   = {ds_payload, src1_val, src2_val};

  // Slot occupancy; a flush wins over any incoming payload
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid <= 1'b0;
    end else if (ds_flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_payload <= '0;
    end else if (!ds_flush && ds_allowin && fs_to_ds_valid) begin
      ds_payload <= fs_ds_bus_t'(fs_to_ds_bus);
    end
  end

  // Saturating hazard-stall counter; the flush cycle itself is not a stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (ds_valid && !ds_ready_go && !ds_flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
